// File: rtl/nn_config_pkg.sv
// Shared types for the neuron weight-fetch path.
//   fetch_state_t : controller FSM states (IDLE, FETCH, DRAIN)
//   FIFO_DEPTH    : depth of the weight output buffer
//   FIFO_CNT_W    : width of the buffer occupancy count
package nn_config_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/weight_stream_fifo2.sv
// Two-entry FIFO of {last, data} words feeding the weight stream.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   push_i              : write push_last_i/push_data_i at the next edge
//   push_last_i         : last flag stored with the word
//   push_data_i         : weight word
//   pop_i               : remove the head entry at the next edge
//   count_o             : current occupancy (0..2)
//   head_last_o         : last flag of the head entry
//   head_data_o         : head word; holds its previous value when empty
module weight_stream_fifo2
  import nn_config_pkg::*;
#(
  parameter int unsigned data_width = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic                  push_last_i,
  input  logic [data_width-1:0] push_data_i,
  input  logic                  pop_i,
  output logic [FIFO_CNT_W-1:0] count_o,
  output logic                  head_last_o,
  output logic [data_width-1:0] head_data_o
);

  logic [FIFO_CNT_W-1:0] count_q;
  logic                  head_last_q;
  logic [data_width-1:0] head_data_q;
  logic                  tail_last_q;
  logic [data_width-1:0] tail_data_q;
  logic                  do_pop;
  logic                  do_push;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q < FIFO_CNT_W'(FIFO_DEPTH)) || do_pop);

  // Shift-register organisation: the head entry is always its own register,
  // so the head keeps showing the last popped word while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      head_last_q <= 1'b0;
      head_data_q <= '0;
      tail_last_q <= 1'b0;
      tail_data_q <= '0;
    end else begin
      unique case ({do_push, do_pop})
        2'b10: begin
          if (count_q == '0) begin
            head_last_q <= push_last_i;
            head_data_q <= push_data_i;
          end else begin
            tail_last_q <= push_last_i;
            tail_data_q <= push_data_i;
          end
          count_q <= count_q + 1'b1;
        end
        2'b01: begin
          if (count_q == FIFO_CNT_W'(FIFO_DEPTH)) begin
            head_last_q <= tail_last_q;
            head_data_q <= tail_data_q;
          end
          count_q <= count_q - 1'b1;
        end
        2'b11: begin
          if (count_q == FIFO_CNT_W'(1)) begin
            head_last_q <= push_last_i;
            head_data_q <= push_data_i;
          end else begin
            head_last_q <= tail_last_q;
            head_data_q <= tail_data_q;
            tail_last_q <= push_last_i;
            tail_data_q <= push_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign count_o     = count_q;
  assign head_last_o = head_last_q;
  assign head_data_o = head_data_q;

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Read-side sequencer for a synchronous-read weight ROM (1-cycle latency).
// On start it reads addresses 0..num_weight-1 and streams the returned words
// as a valid/ready stream with a last flag, absorbing consumer backpressure.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a weight pass (sampled only in IDLE)
//   busy       : pass in progress
//   done       : one-cycle pulse after the final beat handshakes
//   ren, radd  : ROM read enable / address
//   wdata      : ROM read data, valid the cycle after ren
//   m_valid, m_ready, m_data, m_last : output weight stream
module weight_fetch_ctrl
  import nn_config_pkg::*;
#(
  parameter int unsigned num_weight    = 784,
  parameter int unsigned data_width    = 16,
  parameter int unsigned address_width = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     ren,
  output logic [address_width-1:0] radd,
  input  logic [data_width-1:0]    wdata,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [data_width-1:0]    m_data,
  output logic                     m_last
);

  localparam logic [address_width-1:0] LAST_ADDR = address_width'(num_weight - 1);

  fetch_state_t             state_q;
  logic [address_width-1:0] addr_q;
  logic                     inflight_q;
  logic                     inflight_last_q;
  logic                     done_q;

  logic [FIFO_CNT_W-1:0]    count;
  logic                     head_last;
  logic [data_width-1:0]    head_data;
  logic                     pop;
  logic                     last_addr;
  logic [2:0]               occupied;
  logic                     credit_ok;

  assign m_valid   = (count != '0);
  assign pop       = m_valid & m_ready;
  assign last_addr = (addr_q == LAST_ADDR);

  // A read may issue only if the word it returns is guaranteed a buffer slot:
  // buffered + in-flight - leaving-this-cycle must be below the buffer depth.
  assign occupied  = 3'(count) + 3'(inflight_q);
  assign credit_ok = occupied < (3'(FIFO_DEPTH) + 3'(pop));

  assign ren     = (state_q == FETCH) && credit_ok;
  assign radd    = addr_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign m_data  = head_data;
  assign m_last  = head_last & m_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      inflight_q      <= ren;
      inflight_last_q <= ren & last_addr;
      done_q          <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= FETCH;
            addr_q  <= '0;
          end
        end
        FETCH: begin
          // The counter stops on the last address instead of wrapping.
          if (ren) begin
            if (last_addr) state_q <= DRAIN;
            else           addr_q  <= addr_q + 1'b1;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  weight_stream_fifo2 #(
    .data_width(data_width)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_last_i(inflight_last_q),
    .push_data_i(wdata),
    .pop_i      (pop),
    .count_o    (count),
    .head_last_o(head_last),
    .head_data_o(head_data)
  );

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
module tb_weight_fetch_ctrl;

  localparam int NW = 784;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        busy, done, ren;
  logic [9:0]  radd;
  logic [15:0] wdata;
  logic        m_valid, m_ready, m_last;
  logic [15:0] m_data;

  logic        start1;
  logic        busy1, done1, ren1;
  logic [9:0]  radd1;
  logic [15:0] wdata1;
  logic        m_valid1, m_ready1, m_last1;
  logic [15:0] m_data1;

  weight_fetch_ctrl #(
    .num_weight(NW), .data_width(16), .address_width(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .ren(ren), .radd(radd), .wdata(wdata), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  weight_fetch_ctrl #(
    .num_weight(1), .data_width(16), .address_width(10)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .ren(ren1), .radd(radd1), .wdata(wdata1), .m_valid(m_valid1),
    .m_ready(m_ready1), .m_data(m_data1), .m_last(m_last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: word i = i for the main instance, i + 0x0BEE for the single-weight one
  always @(posedge clk) begin
    if (ren)  wdata  <= 16'(radd);
    if (ren1) wdata1 <= 16'(radd1) + 16'h0BEE;
  end

  // m_ready driver: fixed value or random 50%
  bit rdy_mode;
  bit rdy_val;
  always @(posedge clk) begin
    #1;
    m_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  int unsigned n_checks, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard and stream monitor
  logic [16:0] exp_q[$];
  bit          mon_en;
  int unsigned issued, popped, done_cnt, cyc, first_hs, last_hs;
  bit          prev_stall;
  logic [15:0] prev_data;
  logic        prev_last;

  always @(negedge clk) begin
    logic [16:0] e;
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else if (mon_en) begin
      if (ren) issued++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("extra_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("beat_data", m_data, e[15:0]);
          chk("beat_last", m_last, e[16]);
        end
        if (popped == 0) first_hs = cyc;
        last_hs = cyc;
        popped++;
      end
      chk("credit", (issued - popped) <= 2, 1);
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", m_last, prev_last);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) done_cnt++;
    end
  end

  task automatic begin_pass();
    exp_q.delete();
    issued = 0; popped = 0; done_cnt = 0; first_hs = 0; last_hs = 0;
    for (int i = 0; i < NW; i++) exp_q.push_back({(i == NW - 1), 16'(i)});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", seen, 1);
    if (seen) chk("busy_at_done", busy, 0);
  endtask

  task automatic wait_pop(input int unsigned n, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (popped >= n && m_valid) seen = 1'b1;
    end
    chk("reach_beat", seen, 1);
  endtask

  task automatic finish_pass();
    @(negedge clk); #1;
    chk("beat_count", popped, NW);
    chk("queue_empty", exp_q.size(), 0);
    chk("done_once", done_cnt, 1);
    chk("done_pulse_end", done, 0);
  endtask

  typedef struct {
    logic        rdy;
    logic        ren;
    logic [9:0]  radd;
    logic        valid;
    logic [15:0] data;
  } row_t;
  row_t tbl[24];

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; m_ready1 = 1'b1;
    rdy_mode = 1'b0; rdy_val = 1'b0; mon_en = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);
    chk("rst_ren", ren, 0);       chk("rst_radd", radd, 0);
    chk("rst_valid", m_valid, 0); chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);   chk("rst1_valid", m_valid1, 0);
    chk("rst1_busy", busy1, 0);
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Full pass, consumer always ready
    rdy_val = 1'b1;
    begin_pass();
    pulse_start();
    @(negedge clk);
    chk("lat_c0_valid", m_valid, 0); chk("lat_c0_ren", ren, 1);
    chk("lat_c0_radd", radd, 0);     chk("lat_c0_busy", busy, 1);
    @(negedge clk);
    chk("lat_c1_valid", m_valid, 0);
    @(negedge clk);
    chk("lat_c2_valid", m_valid, 1);
    wait_done(2000);
    finish_pass();
    chk("no_bubbles", last_hs - first_hs, NW - 1);

    // Random backpressure
    begin_pass();
    rdy_mode = 1'b1;
    pulse_start();
    wait_done(6000);
    finish_pass();
    rdy_mode = 1'b0;

    // Consumer stalled for 20 cycles after start, then released
    for (int k = 0; k < 24; k++) begin
      tbl[k].rdy   = (k >= 20);
      tbl[k].ren   = (k < 2) || (k >= 20);
      tbl[k].radd  = (k < 2) ? 10'(k) : (k < 20) ? 10'd2 : 10'(k - 18);
      tbl[k].valid = (k >= 2);
      tbl[k].data  = (k < 20) ? 16'd0 : 16'(k - 20);
    end
    begin_pass();
    rdy_val = tbl[0].rdy;
    pulse_start();
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      chk($sformatf("stall_ren[%0d]", k), ren, tbl[k].ren);
      chk($sformatf("stall_radd[%0d]", k), radd, tbl[k].radd);
      chk($sformatf("stall_mvalid[%0d]", k), m_valid, tbl[k].valid);
      if (tbl[k].valid) chk($sformatf("stall_mdata[%0d]", k), m_data, tbl[k].data);
      if (k < 23) rdy_val = tbl[k + 1].rdy;
    end
    wait_done(2000);
    finish_pass();

    // start re-pulsed mid-pass, then back-to-back start during done
    begin_pass();
    rdy_val = 1'b1;
    pulse_start();
    wait_pop(100, 1000);
    pulse_start();
    wait_done(2000);
    #1;
    chk("midstart_beats", popped, NW);
    chk("midstart_queue", exp_q.size(), 0);
    begin_pass();
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_ren", ren, 1); chk("b2b_radd", radd, 0); chk("b2b_busy", busy, 1);
    wait_done(2000);
    finish_pass();

    // Reset in the middle of a pass
    begin_pass();
    pulse_start();
    wait_pop(300, 1000);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);     chk("arst_done", done, 0);
    chk("arst_ren", ren, 0);       chk("arst_radd", radd, 0);
    chk("arst_valid", m_valid, 0); chk("arst_data", m_data, 0);
    chk("arst_last", m_last, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_cnt, 0);
    begin_pass();
    rdy_mode = 1'b1;
    pulse_start();
    wait_done(6000);
    finish_pass();
    rdy_mode = 1'b0;

    // Single-weight instance
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("nw1_c0_ren", ren1, 1); chk("nw1_c0_radd", radd1, 0); chk("nw1_c0_busy", busy1, 1);
    @(negedge clk);
    chk("nw1_c1_ren", ren1, 0); chk("nw1_c1_valid", m_valid1, 0); chk("nw1_c1_busy", busy1, 1);
    @(negedge clk);
    chk("nw1_c2_valid", m_valid1, 1); chk("nw1_c2_last", m_last1, 1);
    chk("nw1_c2_data", m_data1, 16'h0BEE); chk("nw1_c2_done", done1, 0);
    @(negedge clk);
    chk("nw1_c3_done", done1, 1); chk("nw1_c3_busy", busy1, 0); chk("nw1_c3_valid", m_valid1, 0);
    @(negedge clk);
    chk("nw1_c4_done", done1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
Read-side sequencer for a neuron's synchronous-read weight ROM (1-cycle read latency, ren/radd in, wout out).
On a start pulse it walks addresses 0..num_weight-1 and drives ren/radd. It captures the returned words into a 2-entry output buffer and presents them as a valid/ready stream with a last flag.
It sits between the weight ROM and the neuron MAC datapath. It absorbs MAC backpressure without dropping or duplicating weights.

Parameters:
num_weight, 784, number of weights to stream per start; legal range 1..2**address_width
data_width, 16, weight word width
address_width, 10, ROM address width

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin one full weight pass; sampled only in IDLE
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the final beat handshakes
ren  output  1  ROM read enable
radd  output  address_width  ROM read address
wdata  input  data_width  ROM read data, valid the cycle after a cycle with ren=1
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  data_width  weight word
m_last  output  1  high with the beat carrying address num_weight-1

Behaviour:
- Reset: clk and rst_n, reset asynchronous and active-low. All state clears immediately on rst_n low.
  - Outputs at reset: busy=0, done=0, ren=0, radd=0, m_valid=0, m_data=0, m_last=0.
  - Buffer is empty, in-flight flag cleared, state IDLE.
  - Reset mid-pass abandons the pass. No done pulse is generated.
- States:
  - IDLE: start=1 moves to FETCH at the edge and clears the address counter.
  - FETCH: issues reads. After the read for num_weight-1 is issued, moves to DRAIN.
  - DRAIN: waits for the in-flight read and the buffer to empty, i.e. the last beat handshakes. Then moves to IDLE with done=1 for exactly that one cycle.
- start in FETCH or DRAIN is ignored.
- ren is combinational and asserted only in FETCH when credit allows: occupancy + inflight - pop < 2.
  - pop = m_valid & m_ready.
  - inflight = registered copy of the previous cycle's ren.
  - The credit rule guarantees the buffer never overflows.
- radd equals the address counter. The counter increments on each cycle with ren=1.
- The counter never wraps: the last address is num_weight-1, then the state leaves FETCH. radd holds its last value afterwards.
- Capture: when inflight=1, wdata is written into the buffer at the next edge. The last flag is stored alongside the data.
- Latency: start sampled at edge E0; ren=1 with radd=0 in the cycle after E0; m_valid=1 after E2.
- Throughput: with m_ready held high, one beat per cycle after the first, with no bubbles.
- Buffer is FIFO order. A write and a pop in the same cycle are both honoured.
- m_data and m_last hold stable while m_valid=1 and m_ready=0.
- m_data is undefined when m_valid=0 and holds its last value.
- num_weight=1: a single read is issued and FETCH moves to DRAIN immediately. The single beat has m_last=1.

Decomposition:
- nn_config_pkg gets the fetch_state_t enum (IDLE, FETCH, DRAIN).
- Sub-module weight_stream_fifo2: 2-entry FIFO of {last, data}, with push, pop, count, and head outputs.
- The controller holds the FSM, address counter, in-flight flag and credit logic.
- The ROM read-data register is outside this block.

Test Plan:
1. num_weight=784, ROM word i = i, m_ready=1: start pulse → first m_valid two edges after start. 784 beats with values 0..783 on consecutive cycles. m_last only on 783. done pulses once; busy falls with it.
2. Random m_ready (50%): all 784 words arrive in order, no duplicates. At most 2 ROM reads are outstanding or buffered at any time. Data holds while stalled.
3. m_ready=0 for 20 cycles after start: exactly 2 reads issued (radd 0,1), then ren=0. Releasing m_ready streams resume at radd=2.
4. num_weight=1: one read at radd=0, one beat with m_last=1, done one cycle after the handshake.
5. start re-pulsed mid-pass at beat 100: ignored; beat count stays 784. Back-to-back start in the cycle after done begins a new pass from address 0.
6. rst_n low at beat 300 with m_valid=1: outputs clear immediately. After release, a new start yields a full 0..783 pass.
